hall_call_dispatcher: RTL and testbench

// - Shares hall (landing) calls between two elevator cars, car 0 and car 1.
// - Sits between the landing buttons and two per-car controllers. Each car controller drives direction and motor.
// - Flow: latch button presses -> pick the cheaper car for each call -> drive that car's call mask.
//   Re-dispatch a call its car leaves unserved too long; clear a call when a car stops at its floor.

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/dispatch_cost.sv | 42 ++++
 rtl/hall_call_dispatcher.sv | 198 +++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// ============================================================================
// Module      : elevator_pkg
// Description : Shared types and cost-function constants for hall-call dispatch.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam int FLOORS_DEF  = 5;
    localparam int FW          = $clog2(FLOORS_DEF);

    // Cost is distance plus an away penalty of AWAY_MULT * FLOORS; FW+3 bits holds both.
    localparam int AWAY_MULT   = 2;
    localparam int COST_EXTRA  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ASG0 = 2'd2,
        ASG1 = 2'd3
    } call_state_t;

endpackage

`default_nettype wire

// File: rtl/dispatch_cost.sv
// ============================================================================
// Module      : dispatch_cost
// Description : Combinational cost and eligibility of one car for one landing.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dispatch_cost #(
    parameter int FLOORS = elevator_pkg::FLOORS_DEF,
    parameter int FW     = $clog2(FLOORS)
) (
    input  logic [FW-1:0]                          f_i,
    input  logic [FW-1:0]                          floor_i,
    input  logic                                   dir_i,
    input  logic                                   busy_i,
    output logic [FW+elevator_pkg::COST_EXTRA-1:0] cost_o,
    output logic                                   eligible_o
);
    import elevator_pkg::*;

    localparam int            CW       = FW + COST_EXTRA;
    localparam logic [CW-1:0] PENALTY  = CW'(AWAY_MULT * FLOORS);
    localparam logic [FW:0]   FLOORS_W = (FW + 1)'(FLOORS);

    logic [FW:0] w_f;
    logic [FW:0] w_floor;
    logic [FW:0] w_dist;
    logic        w_away;

    always_comb begin
        w_f        = {1'b0, f_i};
        w_floor    = {1'b0, floor_i};
        w_dist     = (w_f >= w_floor) ? (w_f - w_floor) : (w_floor - w_f);
        w_away     = busy_i && ((dir_i && (w_f < w_floor)) || (!dir_i && (w_f > w_floor)));
        cost_o     = CW'(w_dist) + (w_away ? PENALTY : '0);
        // A car whose position sensor reads beyond the top landing is out of service.
        eligible_o = (w_floor < FLOORS_W);
    end

endmodule

`default_nettype wire

// File: rtl/hall_call_dispatcher.sv
// ============================================================================
// Module      : hall_call_dispatcher
// Description : Latches landing calls and shares them between two cars.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hall_call_dispatcher #(
    parameter int FLOORS       = elevator_pkg::FLOORS_DEF,
    parameter int FW           = $clog2(FLOORS),
    parameter int REASSIGN_CYC = 200,
    parameter int AGE_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] hall_btn,
    input  logic [FW-1:0]     car0_floor,
    input  logic              car0_at,
    input  logic              car0_dir,
    input  logic              car0_busy,
    input  logic [FW-1:0]     car1_floor,
    input  logic              car1_at,
    input  logic              car1_dir,
    input  logic              car1_busy,
    output logic [FLOORS-1:0] car0_call,
    output logic [FLOORS-1:0] car1_call,
    output logic [FLOORS-1:0] hall_lamp
);
    import elevator_pkg::*;

    localparam int               CW       = FW + COST_EXTRA;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(REASSIGN_CYC - 1);

    logic [FLOORS-1:0] btn_q;
    logic [FLOORS-1:0] w_rise;
    logic [FLOORS-1:0] w_serve;
    logic [FLOORS-1:0] w_pend;
    logic [FLOORS-1:0] w_grant0;
    logic [FLOORS-1:0] w_grant1;
    logic [FW-1:0]     w_pick;
    logic              w_pick_vld;
    logic [CW-1:0]     w_cost0;
    logic [CW-1:0]     w_cost1;
    logic              w_elig0;
    logic              w_elig1;
    logic              toggle_q;
    logic              toggle_d;

    // Tracks the buttons through reset so a button held across release is not a new press.
    always_ff @(posedge clk) begin
        btn_q <= hall_btn;
    end

    assign w_rise = hall_btn & ~btn_q;

    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_pick     = FW'(i);
                w_pick_vld = 1'b1;
            end
        end
    end

    dispatch_cost #(
        .FLOORS     (FLOORS),
        .FW         (FW)
    ) u_cost0 (
        .f_i        (w_pick),
        .floor_i    (car0_floor),
        .dir_i      (car0_dir),
        .busy_i     (car0_busy),
        .cost_o     (w_cost0),
        .eligible_o (w_elig0)
    );

    dispatch_cost #(
        .FLOORS     (FLOORS),
        .FW         (FW)
    ) u_cost1 (
        .f_i        (w_pick),
        .floor_i    (car1_floor),
        .dir_i      (car1_dir),
        .busy_i     (car1_busy),
        .cost_o     (w_cost1),
        .eligible_o (w_elig1)
    );

    // A grant lost to a same-cycle serve leaves the tie toggle untouched.
    always_comb begin
        w_grant0 = '0;
        w_grant1 = '0;
        toggle_d = toggle_q;
        if (w_pick_vld && !w_serve[w_pick]) begin
            if (w_elig0 && w_elig1) begin
                if (w_cost0 < w_cost1) begin
                    w_grant0[w_pick] = 1'b1;
                end else if (w_cost1 < w_cost0) begin
                    w_grant1[w_pick] = 1'b1;
                end else begin
                    if (toggle_q) begin
                        w_grant1[w_pick] = 1'b1;
                    end else begin
                        w_grant0[w_pick] = 1'b1;
                    end
                    toggle_d = ~toggle_q;
                end
            end else if (w_elig0) begin
                w_grant0[w_pick] = 1'b1;
            end else if (w_elig1) begin
                w_grant1[w_pick] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    for (genvar f = 0; f < FLOORS; f++) begin : g_floor
        localparam logic [FW-1:0] IDX = FW'(f);

        call_state_t      state_q;
        call_state_t      state_d;
        logic [AGE_W-1:0] age_q;
        logic [AGE_W-1:0] age_d;

        assign w_serve[f] = (car0_at && (car0_floor == IDX)) ||
                            (car1_at && (car1_floor == IDX));
        assign w_pend[f]  = (state_q == PEND);

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= IDLE;
                age_q   <= '0;
            end else begin
                state_q <= state_d;
                age_q   <= age_d;
            end
        end

        always_comb begin
            state_d = state_q;
            age_d   = age_q;
            if (w_serve[f]) begin
                state_d = IDLE;
                age_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (w_rise[f]) begin
                            state_d = PEND;
                        end
                    end
                    PEND: begin
                        age_d = '0;
                        if (w_grant0[f]) begin
                            state_d = ASG0;
                        end else if (w_grant1[f]) begin
                            state_d = ASG1;
                        end
                    end
                    ASG0, ASG1: begin
                        // Age saturates at its last value until the other car can take the call.
                        if (age_q == AGE_LAST) begin
                            if ((state_q == ASG0) && w_elig1) begin
                                state_d = ASG1;
                                age_d   = '0;
                            end else if ((state_q == ASG1) && w_elig0) begin
                                state_d = ASG0;
                                age_d   = '0;
                            end
                        end else begin
                            age_d = age_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        age_d   = '0;
                    end
                endcase
            end
        end

        assign car0_call[f] = (state_q == ASG0);
        assign car1_call[f] = (state_q == ASG1);
        assign hall_lamp[f] = (state_q != IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_hall_call_dispatcher.sv
// ============================================================================
// Module      : tb_hall_call_dispatcher
// Description : Self-checking bench with a per-landing behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hall_call_dispatcher;

    localparam int FLOORS   = 5;
    localparam int FW       = 3;
    localparam int REASSIGN = 200;
    localparam int M_IDLE   = 0;
    localparam int M_PEND   = 1;
    localparam int M_CAR0   = 2;
    localparam int M_CAR1   = 3;

    logic              clk;
    logic              reset;
    logic [FLOORS-1:0] hall_btn;
    logic [FW-1:0]     car0_floor;
    logic              car0_at;
    logic              car0_dir;
    logic              car0_busy;
    logic [FW-1:0]     car1_floor;
    logic              car1_at;
    logic              car1_dir;
    logic              car1_busy;
    logic [FLOORS-1:0] car0_call;
    logic [FLOORS-1:0] car1_call;
    logic [FLOORS-1:0] hall_lamp;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    hall_call_dispatcher #(
        .FLOORS       (FLOORS),
        .FW           (FW),
        .REASSIGN_CYC (REASSIGN),
        .AGE_W        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hall_btn   (hall_btn),
        .car0_floor (car0_floor),
        .car0_at    (car0_at),
        .car0_dir   (car0_dir),
        .car0_busy  (car0_busy),
        .car1_floor (car1_floor),
        .car1_at    (car1_at),
        .car1_dir   (car1_dir),
        .car1_busy  (car1_busy),
        .car0_call  (car0_call),
        .car1_call  (car1_call),
        .hall_lamp  (hall_lamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [FLOORS-1:0] act,
                                input logic [FLOORS-1:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: each landing is one of idle / waiting / with car 0 / with car 1.
    int               m_st [FLOORS];
    int               m_age[FLOORS];
    bit               m_tog;
    logic [FLOORS-1:0] m_prev;

    function automatic int cost_of(input int f, input int fl, input bit dir, input bit busy);
        int d;
        d = (f > fl) ? f - fl : fl - f;
        if (busy && ((dir && f < fl) || (!dir && f > fl))) d += 2 * FLOORS;
        return d;
    endfunction

    always @(posedge clk) begin
        int nst[FLOORS];
        int nage[FLOORS];
        bit srv[FLOORS];
        bit ok0, ok1;
        int p, win, c0, c1, other;
        if (reset) begin
            for (int f = 0; f < FLOORS; f++) begin
                m_st[f]  = M_IDLE;
                m_age[f] = 0;
            end
            m_tog  = 1'b0;
            m_prev = hall_btn;
        end else begin
            ok0 = int'(car0_floor) < FLOORS;
            ok1 = int'(car1_floor) < FLOORS;
            p = -1;
            for (int f = 0; f < FLOORS; f++) begin
                srv[f] = (car0_at && int'(car0_floor) == f) || (car1_at && int'(car1_floor) == f);
                if (p < 0 && m_st[f] == M_PEND) p = f;
            end
            win = -1;
            if (p >= 0 && !srv[p]) begin
                c0 = cost_of(p, int'(car0_floor), car0_dir, car0_busy);
                c1 = cost_of(p, int'(car1_floor), car1_dir, car1_busy);
                if (ok0 && ok1) begin
                    if (c0 < c1)      win = 0;
                    else if (c1 < c0) win = 1;
                    else begin
                        win   = m_tog ? 1 : 0;
                        m_tog = !m_tog;
                    end
                end else if (ok0) win = 0;
                else if (ok1)     win = 1;
            end
            for (int f = 0; f < FLOORS; f++) begin
                nst[f]  = m_st[f];
                nage[f] = m_age[f];
                if (srv[f]) begin
                    nst[f]  = M_IDLE;
                    nage[f] = 0;
                end else if (m_st[f] == M_IDLE) begin
                    if (hall_btn[f] && !m_prev[f]) nst[f] = M_PEND;
                end else if (m_st[f] == M_PEND) begin
                    if (f == p && win >= 0) begin
                        nst[f]  = (win == 0) ? M_CAR0 : M_CAR1;
                        nage[f] = 0;
                    end
                end else begin
                    other = (m_st[f] == M_CAR0) ? 1 : 0;
                    if (m_age[f] >= REASSIGN - 1) begin
                        if ((other == 1 && ok1) || (other == 0 && ok0)) begin
                            nst[f]  = (other == 1) ? M_CAR1 : M_CAR0;
                            nage[f] = 0;
                        end
                    end else begin
                        nage[f] = m_age[f] + 1;
                    end
                end
            end
            for (int f = 0; f < FLOORS; f++) begin
                m_st[f]  = nst[f];
                m_age[f] = nage[f];
            end
            m_prev = hall_btn;
        end
    end

    always @(negedge clk) begin
        logic [FLOORS-1:0] e0, e1, el;
        if (chk_en) begin
            for (int f = 0; f < FLOORS; f++) begin
                e0[f] = (m_st[f] == M_CAR0);
                e1[f] = (m_st[f] == M_CAR1);
                el[f] = (m_st[f] != M_IDLE);
            end
            chk("model car0_call", car0_call, e0);
            chk("model car1_call", car1_call, e1);
            chk("model hall_lamp", hall_lamp, el);
            chk("calls exclusive", car0_call & car1_call, '0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        hall_btn   = 5'b11111;
        car0_floor = 3'd0; car0_at = 1'b0; car0_dir = 1'b0; car0_busy = 1'b0;
        car1_floor = 3'd4; car1_at = 1'b0; car1_dir = 1'b0; car1_busy = 1'b0;
        step(1);
        chk_en = 1'b1;
        step(9);
        chk("reset car0_call", car0_call, 5'b00000);
        chk("reset car1_call", car1_call, 5'b00000);
        chk("reset hall_lamp", hall_lamp, 5'b00000);
        reset = 1'b0;
        step(3);
        chk("held buttons after reset", hall_lamp, 5'b00000);
        hall_btn = 5'b00000;
        step(2);

        // Nearest car: car 1 is one floor from landing 3.
        hall_btn = 5'b01000;
        step(1);
        chk("nearest lamp n+1", hall_lamp, 5'b01000);
        chk("nearest call n+1", car1_call, 5'b00000);
        hall_btn = 5'b00000;
        step(1);
        chk("nearest car1_call n+2", car1_call, 5'b01000);
        chk("nearest car0_call n+2", car0_call, 5'b00000);
        car1_floor = 3'd3; car1_at = 1'b1;
        step(1);
        car1_at = 1'b0;
        chk("nearest served", hall_lamp, 5'b00000);

        // Away penalty: car 0 climbing past landing 1 costs 11, idle car 1 costs 1.
        car0_floor = 3'd2; car0_busy = 1'b1; car0_dir = 1'b1;
        car1_floor = 3'd0;
        hall_btn = 5'b00010;
        step(1);
        hall_btn = 5'b00000;
        step(1);
        chk("away car1_call", car1_call, 5'b00010);
        car1_floor = 3'd1; car1_at = 1'b1;
        step(1);
        car1_at = 1'b0;
        car0_busy = 1'b0; car0_dir = 1'b0;

        // Tie and toggle.
        car0_floor = 3'd2; car1_floor = 3'd2;
        hall_btn = 5'b00010;
        step(1);
        hall_btn = 5'b00000;
        step(1);
        chk("tie first to car0", car0_call, 5'b00010);
        hall_btn = 5'b01000;
        step(1);
        hall_btn = 5'b00000;
        step(1);
        chk("tie second to car1", car1_call, 5'b01000);
        chk("tie car0 keeps 1", car0_call, 5'b00010);

        // Serve by car 0 at a landing held by car 1, then press plus serve together.
        car0_floor = 3'd3; car0_at = 1'b1;
        step(1);
        chk("serve car1_call", car1_call, 5'b00000);
        chk("serve lamp", hall_lamp, 5'b00010);
        hall_btn = 5'b01000;
        step(1);
        chk("press during serve", hall_lamp, 5'b00010);
        car0_at = 1'b0;
        step(1);
        hall_btn = 5'b00000;
        chk("held after serve", hall_lamp, 5'b00010);
        car0_floor = 3'd1; car0_at = 1'b1;
        step(1);
        car0_at = 1'b0;
        chk("all served", hall_lamp, 5'b00000);

        // Reassignment after REASSIGN cycles.
        car0_floor = 3'd3; car1_floor = 3'd0;
        hall_btn = 5'b10000;
        step(1);
        hall_btn = 5'b00000;
        step(1);
        chk("reassign start car0", car0_call, 5'b10000);
        step(REASSIGN - 1);
        chk("reassign not yet", car1_call, 5'b00000);
        step(1);
        chk("reassign car1_call", car1_call, 5'b10000);
        chk("reassign car0_call", car0_call, 5'b00000);
        car1_floor = 3'd4; car1_at = 1'b1;
        step(1);
        car1_at = 1'b0;

        // Reassignment blocked while car 1 is out of range, released when it returns.
        car0_floor = 3'd3; car1_floor = 3'd7;
        hall_btn = 5'b10000;
        step(1);
        hall_btn = 5'b00000;
        step(1);
        chk("blocked start car0", car0_call, 5'b10000);
        step(250);
        chk("blocked car0 keeps", car0_call, 5'b10000);
        chk("blocked car1 none", car1_call, 5'b00000);
        car1_floor = 3'd0;
        step(1);
        chk("released to car1", car1_call, 5'b10000);
        car0_floor = 3'd4; car0_at = 1'b1;
        step(1);
        car0_at = 1'b0;
        chk("served by other car", hall_lamp, 5'b00000);

        // Both cars ineligible: landing stays pending.
        car0_floor = 3'd6; car1_floor = 3'd7;
        hall_btn = 5'b00100;
        step(1);
        hall_btn = 5'b00000;
        step(3);
        chk("ineligible lamp", hall_lamp, 5'b00100);
        chk("ineligible no call", car0_call | car1_call, 5'b00000);
        car0_floor = 3'd0;
        step(1);
        chk("eligible again", car0_call, 5'b00100);
        car0_floor = 3'd2; car0_at = 1'b1;
        step(1);
        car0_at = 1'b0;

        // Two presses at once: lowest landing dispatched first.
        car0_floor = 3'd0; car1_floor = 3'd4;
        hall_btn = 5'b01010;
        step(1);
        hall_btn = 5'b00000;
        chk("two lamps", hall_lamp, 5'b01010);
        step(1);
        chk("lowest first car0", car0_call, 5'b00010);
        chk("higher waits", car1_call, 5'b00000);
        step(1);
        chk("higher to car1", car1_call, 5'b01000);

        // Reset mid-operation.
        reset = 1'b1;
        step(1);
        chk("mid reset lamp", hall_lamp, 5'b00000);
        chk("mid reset calls", car0_call | car1_call, 5'b00000);
        reset = 1'b0;
        step(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
